// File: rtl/svi_lane_pkg.sv
// Shared types and defaults for the SVI lane scatter block.
//   state_e     : scatter FSM states (StCheck is only reachable with readback enabled)
//   V_DEF       : default lane count
//   TIMEOUT_DEF : default readback timeout in CHECK cycles
package svi_lane_pkg;

  localparam int unsigned V_DEF       = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    StFill,
    StCommit,
    StCheck
  } state_e;

endpackage

// File: rtl/svi_lane_scatter_if.sv
// Bus bundle between the serial producer, the scatter block and the per-lane latches.
//   i_bit, i_valid, o_ready : serial bit stream handshake into the scatter block
//   o_x, o_en               : lane drive and one-cycle latch enable
//   i_y                     : lane readback
//   o_frame_done, o_err     : one-cycle frame status pulses
// Modports: slave = scatter block side, master = environment side.
interface svi_lane_scatter_if #(
  parameter int unsigned V = svi_lane_pkg::V_DEF
) ();

  logic         i_bit;
  logic         i_valid;
  logic         o_ready;
  logic [V-1:0] o_x;
  logic         o_en;
  logic [V-1:0] i_y;
  logic         o_frame_done;
  logic         o_err;

  modport slave (
    input  i_bit, i_valid, i_y,
    output o_ready, o_x, o_en, o_frame_done, o_err
  );

  modport master (
    output i_bit, i_valid, i_y,
    input  o_ready, o_x, o_en, o_frame_done, o_err
  );

endinterface

// File: rtl/svi_lane_readback.sv
// Readback checker: compares lane y against the committed x and counts CHECK cycles.
//   i_clk, i_arst : clock, async active-low reset
//   i_start       : clears the counter (asserted in the COMMIT cycle)
//   i_active      : high in CHECK cycles
//   i_x, i_y      : committed frame and lane readback
//   o_match       : y equals x this cycle
//   o_timeout     : no match and this is the last allowed CHECK cycle
module svi_lane_readback
  import svi_lane_pkg::*;
#(
  parameter int unsigned V       = V_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_start,
  input  logic         i_active,
  input  logic [V-1:0] i_x,
  input  logic [V-1:0] i_y,
  output logic         o_match,
  output logic         o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_match   = (i_y == i_x);
  // Match has priority over timeout in the same cycle.
  assign o_timeout = !o_match && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_start) begin
      cnt_d = '0;
    end else if (i_active && !o_match && !o_timeout) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/svi_lane_scatter.sv
// Producer end of a per-lane SVI bus. Serial bits accepted over valid/ready are
// scattered round-robin into V lanes (first bit -> lane 0). On the final bit the
// whole frame is committed to o_x and o_en pulses for one cycle.
// Optional readback check: define SVI_LANE_READBACK_EN to verify i_y == o_x after
// commit (o_frame_done on match, o_err on timeout). Without it o_frame_done pulses
// the cycle after commit and o_err is tied low.
//   i_clk, i_arst : clock, async active-low reset
//   bus (slave)   : i_bit/i_valid/o_ready, o_x, o_en, i_y, o_frame_done, o_err
module svi_lane_scatter
  import svi_lane_pkg::*;
#(
  parameter int unsigned V       = V_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_arst,
  svi_lane_scatter_if.slave  bus
);

  localparam int unsigned IdxW = (V > 1) ? $clog2(V) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(V - 1);

  state_e         state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  // Bit V-1 is never written: the last lane comes straight from i_bit.
  logic [V-1:0]   shadow_q, shadow_d;
  logic [V-1:0]   x_q, x_d;
  logic           en_q, en_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

`ifdef SVI_LANE_READBACK_EN
  logic chk_match;
  logic chk_timeout;

  svi_lane_readback #(
    .V       (V),
    .TIMEOUT (TIMEOUT)
  ) u_readback (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .i_start   (state_q == StCommit),
    .i_active  (state_q == StCheck),
    .i_x       (x_q),
    .i_y       (bus.i_y),
    .o_match   (chk_match),
    .o_timeout (chk_timeout)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  logic unused_y;
  assign unused_y = ^bus.i_y;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    x_d      = x_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      StFill: begin
        if (bus.i_valid) begin
          if (idx_q == IdxLast) begin
            x_d        = shadow_q;
            x_d[V-1]   = bus.i_bit;
            idx_d      = '0;
            en_d       = 1'b1;
            state_d    = StCommit;
          end else begin
            shadow_d[idx_q] = bus.i_bit;
            idx_d           = idx_q + IdxW'(1);
          end
        end
      end
      StCommit: begin
`ifdef SVI_LANE_READBACK_EN
        state_d = StCheck;
`else
        done_d  = 1'b1;
        state_d = StFill;
`endif
      end
      StCheck: begin
`ifdef SVI_LANE_READBACK_EN
        if (chk_match) begin
          done_d  = 1'b1;
          state_d = StFill;
        end else if (chk_timeout) begin
          err_d   = 1'b1;
          state_d = StFill;
        end
`else
        state_d = StFill;
`endif
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q  <= StFill;
      idx_q    <= '0;
      shadow_q <= '0;
      x_q      <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      x_q      <= x_d;
      en_q     <= en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Gated by reset so the producer sees no ready while the block is held in reset.
  assign bus.o_ready      = (state_q == StFill) && i_arst;
  assign bus.o_x          = x_q;
  assign bus.o_en         = en_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_err        = err_q;

endmodule
